// File: rtl/keyenable_rpt.sv
// Keypad enable stage: synchronises N key lines, debounces "any key down",
// emits a one-cycle enable with latched key code, and can auto-repeat while held.
module keyenable_rpt #(
    parameter int NKEYS       = 10,
    parameter int CODEW       = 4,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8,
    parameter int KEY_POL     = 1
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [NKEYS-1:0] tenkey,
    input  logic             repeat_en,
    output logic             key_enbl,
    output logic [CODEW-1:0] key_code,
    output logic             key_held,
    output logic             multi
);

    localparam int TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] DLY_LD   = TW'(REPEAT_DLY);
    localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE);
    localparam logic [7:0]    DEB_LAST = 8'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [NKEYS-1:0] raw, ke1, ke2;
    logic [7:0]       deb_cnt;
    logic             any;
    logic             press, rel, fire;
    logic [CODEW-1:0] low_idx;
    logic             found, many;

    assign raw = (KEY_POL != 0) ? tenkey : ~tenkey;
    assign any = |ke2;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            ke1 <= '0;
            ke2 <= '0;
        end else begin
            ke1 <= raw;
            ke2 <= ke1;
        end
    end

    // Counter runs only while the synchronised level disagrees with key_held.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            deb_cnt  <= '0;
            key_held <= 1'b0;
        end else if (any != key_held) begin
            if (deb_cnt == DEB_LAST) begin
                deb_cnt  <= '0;
                key_held <= ~key_held;
            end else begin
                deb_cnt <= deb_cnt + 8'd1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign press = any & ~key_held & (deb_cnt == DEB_LAST);
    assign rel   = ~any & key_held & (deb_cnt == DEB_LAST);

    always_comb begin
        low_idx = '0;
        found   = 1'b0;
        many    = 1'b0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (ke2[i]) begin
                if (!found) begin
                    low_idx = CODEW'(i);
                    found   = 1'b1;
                end else begin
                    many = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // The timer fires on the edge it would decrement from 1 to 0, so a load
    // of N yields a pulse exactly N edges later.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nx = HELD;
                    timer_nx = DLY_LD;
                end
            end
            HELD, REPEAT: begin
                if (rel) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (repeat_en) begin
                    if (timer <= TW'(1)) begin
                        fire     = 1'b1;
                        timer_nx = RATE_LD;
                        state_nx = REPEAT;
                    end else begin
                        timer_nx = timer - TW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            key_enbl <= 1'b0;
            key_code <= '0;
            multi    <= 1'b0;
        end else begin
            key_enbl <= press | fire;
            if (press) begin
                key_code <= low_idx;
                multi    <= many;
            end
        end
    end

endmodule

// File: tb/tb_keyenable_rpt.sv
// Bench for keyenable_rpt: stimulus pushes expected pulses (edge, code, multi)
// into a queue; a negedge monitor pops and compares on every key_enbl.
module tb_keyenable_rpt;

    logic       ck        = 1'b0;
    logic       reset     = 1'b0;
    logic [9:0] tenkey    = '0;
    logic       repeat_en = 1'b0;
    logic       key_enbl;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi;

    keyenable_rpt #(
        .NKEYS      (10),
        .CODEW      (4),
        .DEBOUNCE   (4),
        .REPEAT_DLY (32),
        .REPEAT_RATE(8),
        .KEY_POL    (1)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .tenkey   (tenkey),
        .repeat_en(repeat_en),
        .key_enbl (key_enbl),
        .key_code (key_code),
        .key_held (key_held),
        .multi    (multi)
    );

    always #5 ck = ~ck;

    int unsigned cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [3:0]  code;
        logic        multi;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge ck);
    endtask

    task automatic push(input int unsigned at, input logic [3:0] code, input logic m);
        exp_t e;
        e.at    = at;
        e.code  = code;
        e.multi = m;
        sb.push_back(e);
    endtask

    always @(negedge ck) begin
        exp_t e;
        if (key_enbl) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: key_enbl got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("pulse_code", key_code, e.code);
                check("pulse_multi", multi, e.multi);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned c, p, r, d;

        // reset state
        repeat (3) @(negedge ck);
        check("rst_enbl", key_enbl, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi, 0);
        reset = 1'b1;
        c = cyc;
        wait_until(c + 50);
        check("idle_held", key_held, 0);

        // single clean press of key 3, no repeat
        c = cyc;
        tenkey = 10'b0000001000;
        push(c + 6, 4'd3, 1'b0);
        wait_until(c + 5);
        check("press_held_early", key_held, 0);
        wait_until(c + 6);
        check("press_held", key_held, 1);
        wait_until(c + 20);
        r = cyc;
        tenkey = '0;
        wait_until(r + 5);
        check("release_held_early", key_held, 1);
        wait_until(r + 6);
        check("release_held", key_held, 0);
        check("release_code_kept", key_code, 3);
        wait_until(r + 15);

        // short glitches never accepted
        repeat (4) begin
            tenkey[5] = 1'b1;
            repeat (3) @(negedge ck);
            tenkey[5] = 1'b0;
            repeat (3) @(negedge ck);
            check("glitch_held", key_held, 0);
        end
        repeat (10) @(negedge ck);

        // auto-repeat on key 9
        repeat_en = 1'b1;
        c = cyc;
        tenkey = 10'b1000000000;
        p = c + 6;
        push(p, 4'd9, 1'b0);
        push(p + 32, 4'd9, 1'b0);
        push(p + 40, 4'd9, 1'b0);
        push(p + 48, 4'd9, 1'b0);
        push(p + 56, 4'd9, 1'b0);
        wait_until(c + 60);
        r = cyc;
        tenkey = '0;
        wait_until(r + 6);
        check("rpt_release_held", key_held, 0);
        check("rpt_code", key_code, 9);
        repeat_en = 1'b0;
        repeat (10) @(negedge ck);

        // freeze and resume of repeat timer; release coinciding with expiry
        repeat_en = 1'b1;
        c = cyc;
        tenkey = 10'b0000000100;
        p = c + 6;
        push(p, 4'd2, 1'b0);
        push(p + 32, 4'd2, 1'b0);
        push(p + 50, 4'd2, 1'b0);
        wait_until(p + 36);
        repeat_en = 1'b0;
        wait_until(p + 46);
        repeat_en = 1'b1;
        wait_until(p + 52);
        tenkey = '0;
        wait_until(p + 58);
        check("frz_release_held", key_held, 0);
        wait_until(p + 66);
        repeat_en = 1'b0;

        // two keys at once, then lower key drops while upper stays
        c = cyc;
        tenkey = 10'b0001010000;
        push(c + 6, 4'd4, 1'b1);
        wait_until(c + 10);
        tenkey = 10'b0001000000;
        wait_until(c + 30);
        check("multi_code_kept", key_code, 4);
        check("multi_flag_kept", multi, 1);
        check("multi_held", key_held, 1);
        tenkey = '0;
        wait_until(c + 45);
        check("multi_release_held", key_held, 0);

        // reset during repeat of key 7
        repeat_en = 1'b1;
        c = cyc;
        tenkey = 10'b0010000000;
        p = c + 6;
        push(p, 4'd7, 1'b0);
        push(p + 32, 4'd7, 1'b0);
        wait_until(p + 35);
        reset = 1'b0;
        #1;
        check("mid_rst_enbl", key_enbl, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_multi", multi, 0);
        repeat (3) @(negedge ck);
        reset = 1'b1;
        d = cyc;
        push(d + 6, 4'd7, 1'b0);
        wait_until(d + 5);
        check("post_rst_held_early", key_held, 0);
        wait_until(d + 6);
        check("post_rst_held", key_held, 1);
        repeat_en = 1'b0;
        tenkey = '0;
        repeat (15) @(negedge ck);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keyenable_rpt.md
Name: keyenable_rpt

Overview:
Parametrised successor to the ten-key enable stage. It synchronises N raw key lines and debounces the "any key pressed" condition with a programmable stable-count. On each debounced press it emits a one-cycle enable pulse with a latched binary key code. An optional auto-repeat mode re-issues the pulse while a key is held. It sits between the keypad pins and the digit-entry/command logic.

Parameters:
NKEYS, 10, number of key inputs (2..64)
CODEW, 4, key_code width; must satisfy 2**CODEW >= NKEYS
DEBOUNCE, 4, consecutive stable cycles required to accept a press or release (1..255)
REPEAT_DLY, 32, cycles held after the press pulse before the first repeat pulse (>=2)
REPEAT_RATE, 8, cycles between subsequent repeat pulses (>=2)
KEY_POL, 1, raw key level meaning "pressed" (1 = active-high, 0 = active-low)

Ports:
ck  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately
tenkey  input  NKEYS  raw, asynchronous key lines
repeat_en  input  1  auto-repeat enable; synchronous level, sampled every cycle
key_enbl  output  1  one-cycle pulse per accepted press or repeat
key_code  output  CODEW  index of the lowest-numbered pressed key, latched at press
key_held  output  1  debounced pressed level
multi  output  1  more than one key was down at press acceptance; latched with key_code

Behaviour:
- Reset value of every output and register is 0. The state machine resets to IDLE.
- Synchronisation: each raw line is inverted when KEY_POL=0, then passes through a 2-flop synchroniser (ke1, ke2 per bit).
- any = OR of the ke2 bits.
- Debounce: a counter counts consecutive edges where any differs from key_held. It clears to 0 on any edge where they agree. When it reaches DEBOUNCE, key_held toggles and the counter clears. A bounce shorter than DEBOUNCE produces no effect.
- Latency: after a clean raw press settles, key_held and key_enbl go high on rising edge DEBOUNCE+2, counting the first sampling edge as edge 1.
- Press acceptance (the key_held 0->1 edge), all in the same edge:
  - key_enbl = 1 for exactly one cycle.
  - key_code = lowest index i with ke2[i]=1.
  - multi = 1 if popcount(ke2) > 1.
- States:
  - IDLE: on press acceptance -> HELD; load the repeat timer with REPEAT_DLY.
  - HELD: the timer decrements each cycle while repeat_en=1. At 0: pulse key_enbl, reload with REPEAT_RATE, go to REPEAT. If repeat_en=0, the timer holds its value and no repeat pulse is issued.
  - REPEAT: at timer 0, pulse key_enbl and reload with REPEAT_RATE.
  - HELD or REPEAT: on release acceptance (key_held 1->0) -> IDLE. No pulse is issued on release.
- key_code and multi hold their values until the next press acceptance. A change of which key is down while key_held=1 is ignored.
- Release acceptance and a timer expiry in the same cycle: the release wins and no pulse is issued.
- Deasserting repeat_en mid-REPEAT: pulses stop. Reasserting it resumes counting from the frozen timer value.
- Reset asserted mid-hold: all outputs return to 0 at once. After reset is released with the key still held, a full debounce applies before a new pulse.
- key_enbl is never high for two consecutive cycles. This is guaranteed by REPEAT_RATE >= 2.

Test Plan:
1. Reset, then release it with tenkey=0, DEBOUNCE=4 -> all outputs 0. No key_enbl over 50 cycles.
2. Set tenkey[3]=1, hold 20 cycles, then clear -> single key_enbl pulse on edge 6 after the change. key_code=3, multi=0, key_held high then low 6 edges after release. No pulse on release.
3. Glitch tenkey[5] high for 3 cycles, repeated 4 times with 3-cycle gaps -> no key_enbl, key_held stays 0.
4. repeat_en=1, REPEAT_DLY=32, REPEAT_RATE=8, hold tenkey[9] for 60 cycles -> pulses at press, press+32, press+40, press+48, press+56. key_code=9 throughout.
5. Set tenkey=10'b0001010000 simultaneously -> key_code=4, multi=1. Then drop bit 4 while bit 6 stays held -> key_code remains 4 and no new pulse.
6. Assert reset while key 7 is held in REPEAT -> outputs 0 immediately. Release reset with key still held -> first key_enbl on edge 6 after reset deassertion, key_code=7.
